// File: rtl/hazard_if.sv
// Decode-side view of the hazard tracker: D-stage hazard descriptors in,
// stall / forwarding selects / stall counter out.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       D_A1;
    logic [4:0]       D_A2;
    logic [1:0]       D_tuse_rs;
    logic [1:0]       D_tuse_rt;
    logic [4:0]       D_A3;
    logic [1:0]       D_tnew;
    logic             D_RfWr;
    logic             E_clr;

    logic             stall;
    logic [1:0]       fwd_rs_D;
    logic [1:0]       fwd_rt_D;
    logic [1:0]       fwd_rs_E;
    logic [1:0]       fwd_rt_E;
    logic             fwd_rt_M;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_A1, D_A2, D_tuse_rs, D_tuse_rt, D_A3, D_tnew, D_RfWr, E_clr,
        input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
    );

    modport slave (
        input  D_A1, D_A2, D_tuse_rs, D_tuse_rt, D_A3, D_tnew, D_RfWr, E_clr,
        output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
    );
endinterface

// File: rtl/hazard_tracker.sv
// Tuse/Tnew hazard tracker for the five-stage MIPS pipeline: keeps E/M/W
// writer records and derives the D stall, D/E/M forwarding selects and a stall counter.
module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  bus
);

    localparam logic [1:0] D_SRC_RF = 2'd0;
    localparam logic [1:0] D_SRC_E  = 2'd1;
    localparam logic [1:0] D_SRC_M  = 2'd2;
    localparam logic [1:0] D_SRC_W  = 2'd3;
    localparam logic [1:0] E_SRC_PR = 2'd0;
    localparam logic [1:0] E_SRC_M  = 2'd1;
    localparam logic [1:0] E_SRC_W  = 2'd2;

    // M never needs its rs field, and W only ever has tnew 0, so those are not stored.
    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] tnew;
    } e_rec_t;

    typedef struct packed {
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] tnew;
    } m_rec_t;

    e_rec_t           e_q, e_d;
    m_rec_t           m_q, m_d;
    logic [4:0]       w_a3_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall;

    function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
        return (r != 5'd0) && (a3 == r);
    endfunction

    // Only the nearest writer counts: an older M value behind a pending E write is stale.
    function automatic logic src_stall(
        input logic [4:0] r,    input logic [1:0] tuse,
        input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic [4:0] m_a3, input logic [1:0] m_tnew
    );
        if (hit(r, e_a3)) return e_tnew > tuse;
        if (hit(r, m_a3)) return m_tnew > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] d_sel(
        input logic [4:0] r,
        input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic [4:0] m_a3, input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        if (hit(r, e_a3)) return (e_tnew == 2'd0) ? D_SRC_E : D_SRC_RF;
        if (hit(r, m_a3)) return (m_tnew == 2'd0) ? D_SRC_M : D_SRC_RF;
        if (hit(r, w_a3)) return D_SRC_W;
        return D_SRC_RF;
    endfunction

    function automatic logic [1:0] e_sel(
        input logic [4:0] r,
        input logic [4:0] m_a3, input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        if (hit(r, m_a3) && (m_tnew == 2'd0)) return E_SRC_M;
        if (hit(r, w_a3))                     return E_SRC_W;
        return E_SRC_PR;
    endfunction

    always_comb begin
        stall = src_stall(bus.D_A1, bus.D_tuse_rs, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew)
              | src_stall(bus.D_A2, bus.D_tuse_rt, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew);
    end

    always_comb begin
        bus.stall     = stall;
        bus.fwd_rs_D  = d_sel(bus.D_A1, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
        bus.fwd_rt_D  = d_sel(bus.D_A2, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
        bus.fwd_rs_E  = e_sel(e_q.a1, m_q.a3, m_q.tnew, w_a3_q);
        bus.fwd_rt_E  = e_sel(e_q.a2, m_q.a3, m_q.tnew, w_a3_q);
        bus.fwd_rt_M  = hit(m_q.a2, w_a3_q);
        bus.stall_cnt = cnt_q;
    end

    // A stalled or squashed D slot enters E as an all-zero bubble.
    always_comb begin
        e_d = '0;
        if (!stall && !bus.E_clr) begin
            e_d.a1   = bus.D_A1;
            e_d.a2   = bus.D_A2;
            e_d.a3   = bus.D_RfWr ? bus.D_A3 : 5'd0;
            e_d.tnew = bus.D_tnew;
        end
        m_d.a2   = e_q.a2;
        m_d.a3   = e_q.a3;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    end

    // NOTE: non-blocking assignments so every record advances from the same
    // pre-edge snapshot; blocking ones would let E shoot straight through to W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_a3_q <= '0;
            cnt_q  <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_a3_q <= m_q.a3;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed hazard scenarios plus
// randomized traffic against a timestamp-based model of operand readiness.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] d_a1 = '0, d_a2 = '0, d_a3 = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic       d_rfwr = 1'b0, e_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_if #(.CNT_W(16)) bus16 ();
    hazard_if #(.CNT_W(4))  bus4 ();

    assign bus16.D_A1 = d_a1;           assign bus4.D_A1 = d_a1;
    assign bus16.D_A2 = d_a2;           assign bus4.D_A2 = d_a2;
    assign bus16.D_tuse_rs = d_tuse_rs; assign bus4.D_tuse_rs = d_tuse_rs;
    assign bus16.D_tuse_rt = d_tuse_rt; assign bus4.D_tuse_rt = d_tuse_rt;
    assign bus16.D_A3 = d_a3;           assign bus4.D_A3 = d_a3;
    assign bus16.D_tnew = d_tnew;       assign bus4.D_tnew = d_tnew;
    assign bus16.D_RfWr = d_rfwr;       assign bus4.D_RfWr = d_rfwr;
    assign bus16.E_clr = e_clr;         assign bus4.E_clr = e_clr;

    hazard_tracker #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    hazard_tracker #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    // Model: each in-flight writer remembers the absolute cycle its result becomes
    // available; tnew is just the distance to that cycle. Index 0/1/2 = E/M/W.
    typedef struct {
        int a1;
        int a2;
        int a3;
        int ready;
    } ent_t;

    ent_t pipe[3];
    int   now = 0;
    int   exp_cnt16 = 0;
    int   exp_cnt4 = 0;

    function automatic int tnew_at(int s);
        int t;
        if (s == 2) return 0;
        t = pipe[s].ready - now;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int nearest(int r);
        if (r == 0) return -1;
        for (int s = 0; s < 3; s++) if (pipe[s].a3 == r) return s;
        return -1;
    endfunction

    function automatic bit src_stalls(int r, int tuse);
        int s;
        s = nearest(r);
        return (s >= 0) && (tnew_at(s) > tuse);
    endfunction

    function automatic int d_sel(int r);
        int s;
        s = nearest(r);
        if (s < 0) return 0;
        return (tnew_at(s) == 0) ? s + 1 : 0;
    endfunction

    function automatic int e_sel(int r);
        if (r == 0) return 0;
        if (pipe[1].a3 == r && tnew_at(1) == 0) return 1;
        if (pipe[2].a3 == r) return 2;
        return 0;
    endfunction

    function automatic bit mdl_stall();
        return src_stalls(int'(d_a1), int'(d_tuse_rs)) || src_stalls(int'(d_a2), int'(d_tuse_rt));
    endfunction

    function automatic bit mdl_fwd_m();
        return (pipe[1].a2 != 0) && (pipe[2].a3 == pipe[1].a2);
    endfunction

    task automatic mdl_clear();
        for (int s = 0; s < 3; s++) pipe[s] = '{a1: 0, a2: 0, a3: 0, ready: 0};
        exp_cnt16 = 0;
        exp_cnt4 = 0;
    endtask

    task automatic set_d(input int a1, input int a2, input int tuse_rs, input int tuse_rt,
                         input int a3, input int tnew, input bit rfwr, input bit clr);
        d_a1 = 5'(a1); d_a2 = 5'(a2); d_tuse_rs = 2'(tuse_rs); d_tuse_rt = 2'(tuse_rt);
        d_a3 = 5'(a3); d_tnew = 2'(tnew); d_rfwr = rfwr; e_clr = clr;
        #1;
    endtask

    task automatic idle();
        set_d(0, 0, 3, 3, 0, 0, 1'b0, 1'b0);
    endtask

    // Advance one clock edge and move the model along with it.
    task automatic tick();
        bit s;
        s = mdl_stall();
        @(posedge clk);
        #1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (s || e_clr) pipe[0] = '{a1: 0, a2: 0, a3: 0, ready: 0};
        else pipe[0] = '{a1: int'(d_a1), a2: int'(d_a2), a3: d_rfwr ? int'(d_a3) : 0,
                         ready: now + 1 + int'(d_tnew)};
        now++;
        if (s && exp_cnt16 < 65535) exp_cnt16++;
        if (s && exp_cnt4 < 15) exp_cnt4++;
    endtask

    task automatic flush();
        idle();
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        mdl_clear();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        if ({bus16.stall, bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E, bus16.fwd_rt_E,
             bus16.fwd_rt_M} !== 10'd0 || bus16.stall_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: stall=%0b cnt=%0d want all 0", bus16.stall, bus16.stall_cnt);
        end
        vectors++;
        set_d(0, 0, 3, 3, 6, 2, 1'b1, 1'b0);
        tick();
        set_d(6, 0, 0, 3, 5, 2, 1'b1, 1'b0);
        repeat (3) tick();
        set_d(5, 5, 0, 0, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b1 || bus16.stall_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL reset_prestate: stall=%0b cnt=%0d want 1/2", bus16.stall, bus16.stall_cnt);
        end
        vectors++;
        reset = 1'b0;
        #1;
        if (bus16.stall !== 1'b0 || bus16.stall_cnt !== 16'd0 || bus16.fwd_rs_D !== 2'd0 ||
            bus16.fwd_rt_D !== 2'd0 || bus16.fwd_rs_E !== 2'd0 || bus16.fwd_rt_E !== 2'd0 ||
            bus16.fwd_rt_M !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: stall=%0b cnt=%0d fwdD=%0d/%0d want all 0",
                     bus16.stall, bus16.stall_cnt, bus16.fwd_rs_D, bus16.fwd_rt_D);
        end
        vectors++;
        #1;
        mdl_clear();
        reset = 1'b1;
        #1;
        idle();
    endtask

    task automatic test_load_use();
        set_d(0, 0, 3, 3, 8, 2, 1'b1, 1'b0);
        tick();
        set_d(8, 0, 1, 3, 10, 1, 1'b1, 1'b0);
        if (bus16.stall !== 1'b1) begin
            miscompares++; $display("FAIL load_use_stall1: got %0b want 1", bus16.stall);
        end
        vectors++;
        tick();
        if (bus16.stall !== 1'b0) begin
            miscompares++; $display("FAIL load_use_release: got %0b want 0", bus16.stall);
        end
        vectors++;
        tick();
        idle();
        if (bus16.fwd_rs_E !== 2'd2) begin
            miscompares++; $display("FAIL load_use_fwd_rs_E: got %0d want 2", bus16.fwd_rs_E);
        end
        vectors++;
        if (bus16.stall_cnt !== 16'd1) begin
            miscompares++; $display("FAIL load_use_cnt: got %0d want 1", bus16.stall_cnt);
        end
        vectors++;
        flush();
    endtask

    task automatic test_branch_alu();
        set_d(0, 0, 3, 3, 9, 1, 1'b1, 1'b0);
        tick();
        set_d(9, 0, 0, 3, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b1) begin
            miscompares++; $display("FAIL branch_stall: got %0b want 1", bus16.stall);
        end
        vectors++;
        tick();
        if (bus16.stall !== 1'b0 || bus16.fwd_rs_D !== 2'd2) begin
            miscompares++;
            $display("FAIL branch_fwd_rs_D: stall=%0b fwd=%0d want 0/2", bus16.stall, bus16.fwd_rs_D);
        end
        vectors++;
        tick();
        flush();
    endtask

    task automatic test_nearest_zero_clr();
        set_d(1, 2, 1, 1, 4, 1, 1'b1, 1'b0);
        tick();
        set_d(1, 3, 1, 1, 4, 1, 1'b1, 1'b0);
        tick();
        set_d(0, 4, 3, 2, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b0) begin
            miscompares++; $display("FAIL nearest_sw_stall: got %0b want 0", bus16.stall);
        end
        vectors++;
        tick();
        idle();
        if (bus16.fwd_rt_E !== 2'd1) begin
            miscompares++; $display("FAIL nearest_fwd_rt_E: got %0d want 1", bus16.fwd_rt_E);
        end
        vectors++;
        flush();
        set_d(0, 0, 3, 3, 0, 2, 1'b1, 1'b0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b0 || bus16.fwd_rs_D !== 2'd0 || bus16.fwd_rt_D !== 2'd0) begin
            miscompares++;
            $display("FAIL r0_no_hazard: stall=%0b fwd=%0d/%0d want 0", bus16.stall,
                     bus16.fwd_rs_D, bus16.fwd_rt_D);
        end
        vectors++;
        flush();
        set_d(0, 0, 3, 3, 4, 2, 1'b1, 1'b1);
        tick();
        set_d(4, 0, 0, 3, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b0 || bus16.fwd_rs_D !== 2'd0) begin
            miscompares++;
            $display("FAIL eclr_squash: stall=%0b fwd=%0d want 0/0", bus16.stall, bus16.fwd_rs_D);
        end
        vectors++;
        flush();
    endtask

    task automatic test_store_from_w();
        set_d(0, 0, 3, 3, 7, 2, 1'b1, 1'b0);
        tick();
        set_d(0, 7, 3, 2, 0, 0, 1'b0, 1'b0);
        if (bus16.stall !== 1'b0) begin
            miscompares++; $display("FAIL store_stall: got %0b want 0", bus16.stall);
        end
        vectors++;
        tick();
        idle();
        tick();
        if (bus16.fwd_rt_M !== 1'b1) begin
            miscompares++; $display("FAIL store_fwd_rt_M: got %0b want 1", bus16.fwd_rt_M);
        end
        vectors++;
        flush();
    endtask

    task automatic test_saturation();
        int stalls = 0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            set_d(0, 0, 3, 3, 11, 2, 1'b1, 1'b0);
            tick();
            set_d(11, 0, 0, 3, 0, 0, 1'b0, 1'b0);
            for (int c = 0; c < 3; c++) begin
                if (bus16.stall === 1'b1) stalls++;
                tick();
            end
        end
        idle();
        if (stalls !== 20) begin
            miscompares++; $display("FAIL sat_stall_cycles: got %0d want 20", stalls);
        end
        vectors++;
        if (bus4.stall_cnt !== 4'd15) begin
            miscompares++; $display("FAIL sat_cnt4: got %0d want 15", bus4.stall_cnt);
        end
        vectors++;
        if (bus16.stall_cnt !== 16'd20) begin
            miscompares++; $display("FAIL sat_cnt16: got %0d want 20", bus16.stall_cnt);
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [9:0] act, exp;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
            exp = {mdl_stall(), 2'(d_sel(int'(d_a1))), 2'(d_sel(int'(d_a2))),
                   2'(e_sel(pipe[0].a1)), 2'(e_sel(pipe[0].a2)), mdl_fwd_m(), 1'b0};
            act = {bus16.stall, bus16.fwd_rs_D, bus16.fwd_rt_D, bus16.fwd_rs_E,
                   bus16.fwd_rt_E, bus16.fwd_rt_M, 1'b0};
            if (exp[9]) begin
                exp[8:5] = '0;
                act[8:5] = '0;
            end
            if (act !== exp) begin
                miscompares++;
                $display("FAIL rand_outputs[%0d]: got %b want %b", n, act, exp);
            end
            vectors++;
            if (bus16.stall_cnt !== 16'(exp_cnt16) || bus4.stall_cnt !== 4'(exp_cnt4)) begin
                miscompares++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", n, bus16.stall_cnt,
                         bus4.stall_cnt, exp_cnt16, exp_cnt4);
            end
            vectors++;
            tick();
        end
    endtask

    initial begin
        mdl_clear();
        #12;
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_branch_alu();
        test_nearest_zero_clr();
        test_store_from_w();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
